// File: rtl/cy_status_reg_multi_if.sv
// Bus bundle between the CPU-side logic and the status register.
// The master drives raw status, read strobe and mask writes.
// The slave (the register itself) returns read data, its qualifier and the interrupt.
interface cy_status_reg_multi_if #(
  parameter int Width = 8
);
  logic [Width-1:0] status_in;
  logic             rd_en;
  logic [Width-1:0] rd_data;
  logic             rd_valid;
  logic             mask_wr;
  logic [Width-1:0] mask_wdata;
  logic             intr;

  modport master (
    output status_in, rd_en, mask_wr, mask_wdata,
    input  rd_data, rd_valid, intr
  );

  modport slave (
    input  status_in, rd_en, mask_wr, mask_wdata,
    output rd_data, rd_valid, intr
  );
endinterface

// File: rtl/cy_status_reg_multi.sv
// Multi-channel status register with per-bit capture modes.
// Each channel is either transparent or sticky. A sticky channel is set on a level or on a rising
// edge, and is cleared when software reads it while it is set. The block has a run-time interrupt
// mask, a level or pulse interrupt, and an optional 0/1/2-flop input synchroniser.
module cy_status_reg_multi #(
  parameter int          Width      = 8,
  parameter logic [31:0] StickyMask = 32'h0000_0000,
  parameter logic [31:0] EdgeMask   = 32'h0000_0000,
  parameter logic [31:0] MaskReset  = 32'h0000_007F,
  parameter bit          IntrPulse  = 1'b0,
  parameter int          SyncStages = 0
) (
  input logic                  clock,
  input logic                  reset_n,
  cy_status_reg_multi_if.slave bus
);

  // Parameters are 32 bits wide; only the low Width bits describe real channels.
  // Edge capture is meaningful only on sticky channels, so it is qualified here once.
  localparam logic [Width-1:0] StickyBits = StickyMask[Width-1:0];
  localparam logic [Width-1:0] EdgeBits   = EdgeMask[Width-1:0] & StickyMask[Width-1:0];
  localparam logic [Width-1:0] MaskInit   = MaskReset[Width-1:0];

  logic [Width-1:0] w_s;          // sampled status after the synchroniser
  logic [Width-1:0] r_prev;       // previous sample, used for rising-edge detection
  logic [Width-1:0] r_status;     // status register visible to software
  logic [Width-1:0] r_mask;       // interrupt mask
  logic [Width-1:0] r_rd_data;    // read snapshot
  logic             r_rd_valid;
  logic             r_intr;
  logic             r_any_d;      // last cycle's masked-OR, for pulse mode

  logic [Width-1:0] w_set;
  logic [Width-1:0] w_clr;
  logic [Width-1:0] w_status_nxt;
  logic             w_any;
  logic             w_intr_nxt;

  // ---------------------------------------------------------------------------
  // Input synchroniser: this stage delays status_in by SyncStages cycles.
  // ---------------------------------------------------------------------------
  if (SyncStages == 0) begin : g_nosync
    assign w_s = bus.status_in;
  end else if (SyncStages == 1) begin : g_sync1
    logic [Width-1:0] r_sync0;

    // Single capture flop.
    always_ff @(posedge clock) begin
      // NOTE: clocked state uses non-blocking assignments, so every flop samples pre-edge values.
      if (!reset_n) r_sync0 <= '0;
      else          r_sync0 <= bus.status_in;
    end

    assign w_s = r_sync0;
  end else begin : g_sync2
    logic [Width-1:0] r_sync0;
    logic [Width-1:0] r_sync1;

    // Two-flop chain for asynchronous status sources.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        r_sync0 <= '0;
        r_sync1 <= '0;
      end else begin
        r_sync0 <= bus.status_in;
        r_sync1 <= r_sync0;
      end
    end

    assign w_s = r_sync1;
  end

  // ---------------------------------------------------------------------------
  // Capture logic
  // ---------------------------------------------------------------------------
  // Set event: edge channels use a rising edge, and level channels use the sample itself.
  assign w_set = (w_s & ~r_prev & EdgeBits) | (w_s & ~EdgeBits);

  // A read clears only the sticky bits that were captured at the time of the read.
  assign w_clr = {Width{bus.rd_en}} & r_status;

  // The set term is OR-ed in after the clear, so a set event that coincides with a read is kept.
  assign w_status_nxt = (~StickyBits & w_s) |
                        ( StickyBits & (w_set | (r_status & ~w_clr)));

  // The interrupt uses registered status and mask only.
  assign w_any      = |(r_status & r_mask);
  assign w_intr_nxt = IntrPulse ? (w_any & ~r_any_d) : w_any;

  // Update the sample history and the status register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_prev   <= '0;
      r_status <= '0;
    end else begin
      r_prev   <= w_s;
      r_status <= w_status_nxt;
    end
  end

  // Read port: take a snapshot of the pre-clear status. The snapshot is held between reads.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) r_rd_data <= r_status;
    end
  end

  // Mask register: a write takes effect on the interrupt computed at the next edge.
  always_ff @(posedge clock) begin
    if (!reset_n) r_mask <= MaskInit;
    else if (bus.mask_wr) r_mask <= bus.mask_wdata;
  end

  // Interrupt output and the pulse-mode history.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_intr  <= 1'b0;
      r_any_d <= 1'b0;
    end else begin
      r_intr  <= w_intr_nxt;
      r_any_d <= w_any;
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.intr     = r_intr;

endmodule
